// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the multi-cycle CPU control path.
// Holds the FSM state codes, the opcode/funct values decoded by the
// controller, the datapath mux/ALU encodings, and the packed bundle of
// control outputs. The ALU-control block imports the same ALU_* codes.
package cpu_ctrl_pkg;

    // FSM state codes (plain constants so older blocks can compare raw bits)
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXEC_R    = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_EXEC_I    = 4'd9;
    localparam logic [3:0] S_I_WB      = 4'd10;
    localparam logic [3:0] S_BRANCH    = 4'd11;
    localparam logic [3:0] S_JUMP      = 4'd12;
    localparam logic [3:0] S_JUMP_REG  = 4'd13;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // Funct codes (IR[5:0]) that the controller itself cares about
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;

    // ALUOp
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_RTYPE = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_SLTU  = 3'd5;

    // Mux selects
    localparam logic [1:0] SRCA_PC      = 2'd0;
    localparam logic [1:0] SRCA_REG     = 2'd1;
    localparam logic [1:0] SRCA_SHAMT   = 2'd2;
    localparam logic [1:0] SRCA_ZERO    = 2'd3;
    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;
    localparam logic [1:0] RDST_RT      = 2'd0;
    localparam logic [1:0] RDST_RD      = 2'd1;
    localparam logic [1:0] RDST_RA      = 2'd2;
    localparam logic [1:0] M2R_ALU      = 2'd0;
    localparam logic [1:0] M2R_MDR      = 2'd1;
    localparam logic [1:0] M2R_PC       = 2'd2;

    // All controller outputs as one bundle
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       ext_op;
        logic       lui_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    // Shifts take operand A from the shamt field instead of a register
    function automatic logic is_shift(input logic [5:0] funct);
        return (funct == F_SLL) || (funct == F_SRL) || (funct == F_SRA);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction fields in, datapath controls out.
//   master: the control FSM (reads OpCode/Funct, drives controls)
//   slave : the datapath (drives OpCode/Funct from IR, reads controls)
interface multicycle_control_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       ExtOp;
    logic       LuiOp;
    logic [1:0] PCSource;
    logic       InstrDone;

    modport master (
        input  OpCode, Funct,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
               ExtOp, LuiOp, PCSource, InstrDone
    );

    modport slave (
        output OpCode, Funct,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
               ExtOp, LuiOp, PCSource, InstrDone
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle CPU.
// Steps each instruction through fetch/decode/execute/memory/writeback.
// Outputs are Moore: decoded from the state register and the IR fields.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; forces IDLE
//   bus   - master side of multicycle_control_if (OpCode/Funct in,
//           all datapath write enables and mux selects out)
import cpu_ctrl_pkg::*;

module multicycle_control (
    input  logic               clk,
    input  logic               reset,
    multicycle_control_if.master bus
);

    logic [3:0] state, next_state;
    ctrl_t      c;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_IDLE:     next_state = S_FETCH;
            S_FETCH:    next_state = S_DECODE;
            S_DECODE: begin
                case (bus.OpCode)
                    OP_LW, OP_SW: next_state = S_MEM_ADDR;
                    OP_RTYPE:     next_state = (bus.Funct == F_JR || bus.Funct == F_JALR)
                                               ? S_JUMP_REG : S_EXEC_R;
                    OP_ADDI, OP_ADDIU, OP_ANDI,
                    OP_SLTI, OP_SLTIU, OP_LUI:
                                  next_state = S_EXEC_I;
                    OP_BEQ:       next_state = S_BRANCH;
                    OP_J, OP_JAL: next_state = S_JUMP;
                    default:      next_state = S_FETCH;  // unsupported: NOP
                endcase
            end
            S_MEM_ADDR: next_state = (bus.OpCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: next_state = S_MEM_WB;
            S_EXEC_R:   next_state = S_R_WB;
            S_EXEC_I:   next_state = S_I_WB;
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        c        = '0;
        // Sign extension is the default everywhere except IDLE (all zero)
        c.ext_op = (state != S_IDLE);
        case (state)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_a = SRCA_PC;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_source = PCSRC_ALU;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_IMM_SH2;
                c.alu_op     = ALU_ADD;
                // Unsupported opcode finishes here; PC already advanced
                c.instr_done = (next_state == S_FETCH);
            end
            S_MEM_ADDR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = RDST_RT;
                c.mem_to_reg = M2R_MDR;
                c.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write  = 1'b1;
                c.i_or_d     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_op    = ALU_RTYPE;
                c.alu_src_b = SRCB_REG;
                c.alu_src_a = is_shift(bus.Funct) ? SRCA_SHAMT : SRCA_REG;
            end
            S_R_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = RDST_RD;
                c.mem_to_reg = M2R_ALU;
                c.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                c.alu_src_b = SRCB_IMM;
                case (bus.OpCode)
                    OP_ANDI: begin
                        c.ext_op = 1'b0;
                        c.alu_op = ALU_AND;
                    end
                    OP_SLTI:  c.alu_op = ALU_SLT;
                    OP_SLTIU: c.alu_op = ALU_SLTU;
                    OP_LUI: begin
                        // Result is imm << 16 passed through the adder with A = 0
                        c.lui_op    = 1'b1;
                        c.alu_src_a = SRCA_ZERO;
                        c.alu_op    = ALU_ADD;
                    end
                    default: begin
                        c.alu_src_a = SRCA_REG;
                        c.alu_op    = ALU_ADD;
                    end
                endcase
            end
            S_I_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = RDST_RT;
                c.mem_to_reg = M2R_ALU;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = SRCA_REG;
                c.alu_src_b     = SRCB_REG;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
                c.instr_done    = 1'b1;
            end
            S_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PCSRC_JUMP;
                c.instr_done = 1'b1;
                if (bus.OpCode == OP_JAL) begin
                    c.reg_write  = 1'b1;
                    c.reg_dst    = RDST_RA;
                    c.mem_to_reg = M2R_PC;
                end
            end
            S_JUMP_REG: begin
                c.pc_write   = 1'b1;
                c.pc_source  = PCSRC_REG;
                c.instr_done = 1'b1;
                if (bus.Funct == F_JALR) begin
                    c.reg_write  = 1'b1;
                    c.reg_dst    = RDST_RD;
                    c.mem_to_reg = M2R_PC;
                end
            end
            default: c = '0;
        endcase
    end

    assign bus.PCWrite     = c.pc_write;
    assign bus.PCWriteCond = c.pc_write_cond;
    assign bus.IorD        = c.i_or_d;
    assign bus.MemRead     = c.mem_read;
    assign bus.MemWrite    = c.mem_write;
    assign bus.IRWrite     = c.ir_write;
    assign bus.RegWrite    = c.reg_write;
    assign bus.RegDst      = c.reg_dst;
    assign bus.MemtoReg    = c.mem_to_reg;
    assign bus.ALUSrcA     = c.alu_src_a;
    assign bus.ALUSrcB     = c.alu_src_b;
    assign bus.ALUOp       = c.alu_op;
    assign bus.ExtOp       = c.ext_op;
    assign bus.LuiOp       = c.lui_op;
    assign bus.PCSource    = c.pc_source;
    assign bus.InstrDone   = c.instr_done;

endmodule
